// File: rtl/toggle_line_pkg.sv
// Shared types and width helpers for the toggle-line receiver.
package toggle_line_pkg;

   localparam int unsigned DATA_W_DEF       = 8;
   localparam int unsigned CLKS_PER_BIT_DEF = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   // Bit counter must hold 0..DATA_W.
   function automatic int unsigned bit_cnt_width(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

   // Timer reloads with CLKS_PER_BIT-1 at most.
   function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
      return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/toggle_line_rx_if.sv
// Valid/ready word output of the toggle-line receiver.
interface toggle_line_rx_if
   import toggle_line_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              parity_err;

   modport master (output rx_data, output rx_valid, output parity_err, input rx_ready);
   modport slave  (input rx_data, input rx_valid, input parity_err, output rx_ready);
endinterface

// File: rtl/toggle_rx_bit_timer.sv
// Loadable down-counter producing a one-cycle mid-bit sample tick.
module toggle_rx_bit_timer
   import toggle_line_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned CNT_W        = cnt_width(CLKS_PER_BIT)
) (
   input  logic clk,
   input  logic i_reset_n,
   input  logic i_en,
   input  logic i_load,
   input  logic i_half,
   output logic o_sample_tick_c
);

   // Reload values are one less than the interval: tick fires when the count reaches zero.
   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_half ? HALF_LD : FULL_LD;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_sample_tick_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/toggle_line_rx.sv
// Toggle-encoded (NRZI) frame receiver: start, DATA_W bits LSB first,
// even parity, stop; delivers words through a one-entry valid/ready register.
module toggle_line_rx
   import toggle_line_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            line_in,
   toggle_line_rx_if.master rx,
   output logic            frame_err,
   output logic            overrun,
   output logic            busy
);

   localparam int unsigned BIT_CNT_W = bit_cnt_width(DATA_W);
   localparam int unsigned CNT_W     = cnt_width(CLKS_PER_BIT);

   rx_state_e             r_state;
   rx_state_e             w_state_next;
   logic                  r_busy;
   logic                  r_last_line;
   logic                  r_ref;
   logic                  r_perr;
   logic [DATA_W-1:0]     r_shift;
   logic [BIT_CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0]     r_rx_data;
   logic                  r_rx_valid;
   logic                  r_parity_err;
   logic                  r_frame_err;
   logic                  r_overrun;

   logic w_tick;
   logic w_edge;
   logic w_bit;
   logic w_last_data;
   logic w_tmr_en;
   logic w_tmr_load;
   logic w_tmr_half;

   assign w_edge      = line_in ^ r_last_line;
   assign w_bit       = line_in ^ r_ref;
   assign w_last_data = (r_bit_cnt == BIT_CNT_W'(DATA_W - 1));

   toggle_rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk             (clk),
      .i_reset_n       (reset),
      .i_en            (w_tmr_en),
      .i_load          (w_tmr_load),
      .i_half          (w_tmr_half),
      .o_sample_tick_c (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != IDLE);
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_edge) w_state_next = START;
         START:   if (w_tick) w_state_next = w_bit ? DATA : IDLE;
         DATA:    if (w_tick && w_last_data) w_state_next = PARITY;
         PARITY:  if (w_tick) w_state_next = STOP;
         STOP:    if (w_tick) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Timer control: half-bit load on the start edge, full-bit reload on each continuing sample.
   always_comb begin
      w_tmr_en   = 1'b0;
      w_tmr_load = 1'b0;
      w_tmr_half = 1'b0;
      case (r_state)
         IDLE: begin
            w_tmr_load = w_edge;
            w_tmr_half = 1'b1;
         end
         START: begin
            w_tmr_en   = 1'b1;
            w_tmr_load = w_tick && w_bit;
         end
         DATA, PARITY: begin
            w_tmr_en   = 1'b1;
            w_tmr_load = w_tick;
         end
         STOP:    w_tmr_en = 1'b1;
         default: w_tmr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_line  <= line_in;
         r_ref        <= 1'b0;
         r_perr       <= 1'b0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         if (r_rx_valid && rx.rx_ready) r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_last_line <= line_in;
               if (w_edge) r_ref <= r_last_line;
            end
            START: if (w_tick) begin
               if (w_bit) begin
                  r_ref     <= line_in;
                  r_bit_cnt <= '0;
               end else begin
                  r_last_line <= line_in;
               end
            end
            DATA: if (w_tick) begin
               r_ref             <= line_in;
               r_shift           <= r_shift >> 1;
               r_shift[DATA_W-1] <= w_bit;
               r_bit_cnt         <= r_bit_cnt + BIT_CNT_W'(1);
            end
            PARITY: if (w_tick) begin
               r_ref  <= line_in;
               r_perr <= (^r_shift) ^ w_bit;
            end
            STOP: if (w_tick) begin
               r_last_line <= line_in;
               if (w_bit) begin
                  r_frame_err <= 1'b1;
               end else if (!r_rx_valid || rx.rx_ready) begin
                  r_rx_data    <= r_shift;
                  r_parity_err <= r_perr;
                  r_rx_valid   <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
            end
            default: r_last_line <= line_in;
         endcase
      end
   end

   assign rx.rx_data    = r_rx_data;
   assign rx.rx_valid   = r_rx_valid;
   assign rx.parity_err = r_parity_err;
   assign frame_err     = r_frame_err;
   assign overrun       = r_overrun;
   assign busy          = r_busy;

endmodule

// File: tb/tb_toggle_line_rx.sv
// Directed bench for toggle_line_rx at CLKS_PER_BIT=4, DATA_W=8.
module tb_toggle_line_rx;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CPB    = 4;

   logic clk     = 1'b0;
   logic reset   = 1'b0;
   logic line_in = 1'b1;
   logic frame_err;
   logic overrun;
   logic busy;

   int tests_run    = 0;
   int tests_failed = 0;

   int valid_edge, ovr_edge, ferr_edge;
   int ovr_cnt, ferr_cnt, busy_cnt, valid_cnt;

   toggle_line_rx_if #(.DATA_W(DATA_W)) rx_if ();

   toggle_line_rx #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .line_in   (line_in),
      .rx        (rx_if),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      valid_edge = -1; ovr_edge = -1; ferr_edge = -1;
      ovr_cnt = 0; ferr_cnt = 0; busy_cnt = 0; valid_cnt = 0;
   endtask

   task automatic observe(input int k);
      if (rx_if.rx_valid && valid_edge < 0) valid_edge = k;
      if (overrun) begin ovr_cnt++; if (ovr_edge < 0) ovr_edge = k; end
      if (frame_err) begin ferr_cnt++; if (ferr_edge < 0) ferr_edge = k; end
      if (busy) busy_cnt++;
      if (rx_if.rx_valid) valid_cnt++;
   endtask

   // Transmit one frame as a T flip-flop would; edge 0 is the first edge after the start toggle.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
      logic [10:0] bits;
      int k;
      bits = {stop, par, data, 1'b1};
      clear_stats();
      k = 0;
      for (int b = 0; b < 11; b++) begin
         if (bits[b]) line_in = ~line_in;
         for (int c = 0; c < int'(CPB); c++) begin
            tick();
            observe(k);
            k++;
         end
      end
   endtask

   task automatic consume();
      rx_if.rx_ready = 1'b1;
      tick();
      rx_if.rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; line_in = 1'b1; rx_if.rx_ready = 1'b0;
      tick(); tick();
      tests_run++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || rx_if.parity_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b data=%h perr=%b, expected 0 00 0",
                  rx_if.rx_valid, rx_if.rx_data, rx_if.parity_err);
      end
      tests_run++;
      if (frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got ferr=%b ovr=%b busy=%b, expected 0 0 0", frame_err, overrun, busy);
      end
      reset = 1'b1;
      clear_stats();
      for (int k = 0; k < 60; k++) begin tick(); observe(k); end
      tests_run++;
      if (busy_cnt + valid_cnt + ferr_cnt + ovr_cnt !== 0) begin
         tests_failed++;
         $display("FAIL idle_steady: got busy=%0d valid=%0d ferr=%0d ovr=%0d cycles, expected all 0",
                  busy_cnt, valid_cnt, ferr_cnt, ovr_cnt);
      end
   endtask

   task automatic test_deliver();
      send_frame(8'hA5, 1'b0, 1'b0);
      tests_run++;
      if (valid_edge !== 42) begin
         tests_failed++;
         $display("FAIL deliver_edge: got %0d expected 42", valid_edge);
      end
      tests_run++;
      if (busy_cnt !== 42) begin
         tests_failed++;
         $display("FAIL deliver_busy: got %0d busy cycles expected 42", busy_cnt);
      end
      tests_run++;
      if (rx_if.rx_data !== 8'hA5 || rx_if.parity_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL deliver_data: got %h perr=%b expected a5 perr=0", rx_if.rx_data, rx_if.parity_err);
      end
      repeat (5) tick();
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'hA5) begin
         tests_failed++;
         $display("FAIL deliver_hold: got valid=%b data=%h expected 1 a5", rx_if.rx_valid, rx_if.rx_data);
      end
      consume();
      tests_run++;
      if (rx_if.rx_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL deliver_consume: got valid=%b expected 0", rx_if.rx_valid);
      end
   endtask

   task automatic test_parity_err();
      send_frame(8'h01, 1'b0, 1'b0);
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h01 || rx_if.parity_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL parity_err: got valid=%b data=%h perr=%b expected 1 01 1",
                  rx_if.rx_valid, rx_if.rx_data, rx_if.parity_err);
      end
      consume();
   endtask

   task automatic test_glitch();
      tick();
      line_in = ~line_in;
      tick();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_edge0: got busy=%b expected 1", busy);
      end
      line_in = ~line_in;
      tick();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_edge1: got busy=%b expected 1", busy);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL glitch_edge2: got busy=%b expected 0", busy);
      end
      clear_stats();
      for (int k = 0; k < 12; k++) begin tick(); observe(k); end
      tests_run++;
      if (valid_cnt !== 0 || ferr_cnt !== 0 || busy_cnt !== 0) begin
         tests_failed++;
         $display("FAIL glitch_quiet: got valid=%0d ferr=%0d busy=%0d cycles expected 0 0 0",
                  valid_cnt, ferr_cnt, busy_cnt);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h3C, 1'b0, 1'b0);
      tests_run++;
      if (valid_edge !== 42 || rx_if.rx_data !== 8'h3C || rx_if.parity_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_first: got edge=%0d data=%h perr=%b expected 42 3c 0",
                  valid_edge, rx_if.rx_data, rx_if.parity_err);
      end
      send_frame(8'hC3, 1'b0, 1'b0);
      tests_run++;
      if (ovr_edge !== 42 || ovr_cnt !== 1) begin
         tests_failed++;
         $display("FAIL b2b_overrun: got edge=%0d cycles=%0d expected 42 1", ovr_edge, ovr_cnt);
      end
      tests_run++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h3C) begin
         tests_failed++;
         $display("FAIL b2b_held: got valid=%b data=%h expected 1 3c", rx_if.rx_valid, rx_if.rx_data);
      end
      consume();
   endtask

   task automatic test_frame_err_and_reset();
      send_frame(8'h55, 1'b0, 1'b1);
      tests_run++;
      if (ferr_edge !== 42 || ferr_cnt !== 1) begin
         tests_failed++;
         $display("FAIL frame_err_pulse: got edge=%0d cycles=%0d expected 42 1", ferr_edge, ferr_cnt);
      end
      tests_run++;
      if (valid_cnt !== 0) begin
         tests_failed++;
         $display("FAIL frame_err_valid: got %0d valid cycles expected 0", valid_cnt);
      end
      // Partial all-ones frame; reset is sampled low at edge 20.
      line_in = ~line_in;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (((k + 1) % int'(CPB)) == 0) line_in = ~line_in;
         if (k == 19) reset = 1'b0;
      end
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_midframe: got busy=%b expected 0", busy);
      end
      reset = 1'b1;
      clear_stats();
      for (int k = 0; k < 60; k++) begin tick(); observe(k); end
      tests_run++;
      if (valid_cnt !== 0 || busy_cnt !== 0 || ferr_cnt !== 0) begin
         tests_failed++;
         $display("FAIL reset_no_delivery: got valid=%0d busy=%0d ferr=%0d cycles expected 0 0 0",
                  valid_cnt, busy_cnt, ferr_cnt);
      end
   endtask

   initial begin
      rx_if.rx_ready = 1'b0;
      test_reset();
      test_deliver();
      test_parity_err();
      test_glitch();
      test_back_to_back();
      test_frame_err_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
